inst_queue_mp: RTL and testbench
================================

Name: inst_queue_mp

Overview:
Parametrised multi-port instruction queue between fetch/predecode and the issue stage.
- Accepts up to WR_PORTS instruction entries per cycle and presents up to RD_PORTS oldest entries per cycle.
- Interface is count-based, so lane ordering is explicit.
- Provides exact occupancy and free-slot reporting, a flush input, and sticky overflow/underflow error flags.

Parameters:
DEPTH, 16, number of entries; must be a power of two and at least 2*max(WR_PORTS,RD_PORTS).
WR_PORTS, 2, maximum entries written per cycle.
RD_PORTS, 2, maximum entries consumed per cycle.
CW (localparam), $clog2(DEPTH+1), width of occupancy and free-slot counts.
PW (localparam), $clog2(DEPTH), pointer width.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
flush  in  1  discard all contents this cycle (branch mispredict or exception)
wr_cnt  in  $clog2(WR_PORTS+1)  number of valid write lanes; lanes 0..wr_cnt-1 are valid, lane 0 is oldest
wr_entry  in  WR_PORTS x pipe_entry_t  write payloads
wr_ready  out  1  free_cnt >= WR_PORTS
rd_cnt  in  $clog2(RD_PORTS+1)  number of entries consumed this cycle, taken from lane 0 upward
rd_entry  out  RD_PORTS x pipe_entry_t  oldest entries; lane 0 = head
rd_valid  out  RD_PORTS  thermometer code; bit i = (occupancy > i)
occupancy  out  CW  entries currently held
free_cnt  out  CW  DEPTH - occupancy
ovf_err  out  1  sticky: a write group was rejected
udf_err  out  1  sticky: rd_cnt exceeded occupancy

Behaviour:
- Reset (rst=1 at posedge):
  - wr_ptr=0, rd_ptr=0, occupancy=0, ovf_err=0, udf_err=0.
  - Resulting outputs: free_cnt=DEPTH, wr_ready=1, rd_valid=0, rd_entry all zero.
  - rst dominates flush and all writes/reads. Storage array is not reset.
- Read path, zero latency (combinational from registered state):
  - rd_entry[i] = mem[rd_ptr+i] (mod DEPTH) when rd_valid[i]=1; otherwise all-zero.
- Consume:
  - r_eff = min(rd_cnt, occupancy).
  - If rd_cnt > occupancy, set udf_err; r_eff still applies.
- Write accept:
  - Group is accepted iff wr_cnt <= free_cnt, evaluated on pre-cycle state. Same-cycle reads do NOT create space.
  - Accepted: mem[wr_ptr+i] <= wr_entry[i] for i < wr_cnt; wr_ptr advances by wr_cnt.
  - Rejected: entire group dropped (no partial write), ovf_err set, wr_ptr unchanged.
- Next state (no flush):
  - rd_ptr += r_eff.
  - occupancy += w_eff - r_eff, where w_eff = wr_cnt if accepted, else 0.
  - All pointer arithmetic wraps mod DEPTH (PW bits). Count arithmetic uses CW bits with no overflow by construction.
- Flush (flush=1, rst=0):
  - Next cycle: wr_ptr=rd_ptr=0, occupancy=0.
  - Same-cycle writes and reads are discarded; no error flags are set by that cycle's traffic.
  - ovf_err/udf_err keep their value (only rst clears them).
- Simultaneous read and write on a full or empty queue:
  - Empty + write 2 + read 2 -> reads ignored (r_eff=0), udf_err set, occupancy=2.
  - Full + read 2 + write 2 -> write rejected (pre-cycle free=0), ovf_err set, occupancy=DEPTH-2.
- Wrap: writes/reads straddling index DEPTH-1 -> 0 split across the boundary transparently; lane order preserved.
- No combinational path from wr_* to rd_*: no bypass, so write-to-read latency is 1 cycle.

Decomposition:
- Shared package (def_cpu.svh): pipe_entry_t (existing), plus a new iq_cnt_t/iq_ptr_t typedef family derived from DEPTH.
- Keep wr_ready semantics as a package constant doc reference.
- One natural sub-module: iq_ptr_ctrl, holding pointers, occupancy, accept/r_eff arithmetic and error flags. The top level holds the storage array and the read mux.

Test Plan (DEPTH=16, WR_PORTS=2, RD_PORTS=2):
1. Reset, then idle -> occupancy=0, free_cnt=16, wr_ready=1, rd_valid=2'b00, rd_entry zero, errors 0.
2. Write {A,B}, then {C} on the next cycle, rd_cnt=0 -> after 2 cycles occupancy=3, rd_entry={A,B}, rd_valid=2'b11. Then rd_cnt=1 -> rd_entry={B,C}.
3. Fill to 16 with 8 double writes; write 2 more with rd_cnt=2 in the same cycle -> write rejected, ovf_err=1, occupancy=14, wr_ready=1.
4. Wrap: prime rd_ptr=wr_ptr=15 via 15 writes/reads; write {X,Y} -> X at index 15, Y at index 0; next cycle rd_entry={X,Y}.
5. Occupancy=1 with rd_cnt=2 -> occupancy=0, udf_err=1. Then flush with occupancy=5 plus a write of 2 -> occupancy=0 next cycle, errors unchanged.
6. rst asserted mid-stream with occupancy=9 and pending writes -> next cycle occupancy=0, both error flags 0.

Source files
------------

// File: rtl/inst_queue_mp_pkg.sv
// Shared types for the multi-port instruction queue: pipeline entry payload
// plus count/pointer typedefs derived from the default queue depth.
package inst_queue_mp_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } pipe_entry_t;

  localparam int IQ_DEPTH = 16;
  localparam int IQ_CW    = $clog2(IQ_DEPTH + 1);
  localparam int IQ_PW    = $clog2(IQ_DEPTH);

  typedef logic [IQ_CW-1:0] iq_cnt_t;
  typedef logic [IQ_PW-1:0] iq_ptr_t;

  // wr_ready promises room for a full-width write group, not just one slot
  localparam bit IQ_WR_READY_FULL_GROUP = 1'b1;

endpackage

// File: rtl/inst_queue_mp_ptr_ctrl.sv
// Pointer, occupancy and error-flag bookkeeping for inst_queue_mp.
// Write acceptance is judged on pre-cycle free space only.
module iq_ptr_ctrl
  import inst_queue_mp_pkg::*;
#(
  parameter  int DEPTH    = IQ_DEPTH,
  parameter  int WR_PORTS = 2,
  parameter  int RD_PORTS = 2,
  localparam int CW       = $clog2(DEPTH + 1),
  localparam int PW       = $clog2(DEPTH),
  localparam int WCW      = $clog2(WR_PORTS + 1),
  localparam int RCW      = $clog2(RD_PORTS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [WCW-1:0]      wr_cnt,
  input  logic [RCW-1:0]      rd_cnt,
  output logic                wr_accept,
  output logic [PW-1:0]       wr_ptr,
  output logic [PW-1:0]       rd_ptr,
  output logic [CW-1:0]       occupancy,
  output logic [CW-1:0]       free_cnt,
  output logic                wr_ready,
  output logic [RD_PORTS-1:0] rd_valid,
  output logic                ovf_err,
  output logic                udf_err
);

  logic [CW-1:0] wr_ext;
  logic [CW-1:0] rd_ext;
  logic [CW-1:0] w_eff;
  logic [CW-1:0] r_eff;
  logic          wr_over;
  logic          rd_over;

  assign wr_ext   = CW'(wr_cnt);
  assign rd_ext   = CW'(rd_cnt);
  assign free_cnt = CW'(DEPTH) - occupancy;

  assign wr_over   = wr_ext > free_cnt;
  assign rd_over   = rd_ext > occupancy;
  assign wr_accept = !rst && !flush && !wr_over;
  assign w_eff     = wr_accept ? wr_ext : '0;
  assign r_eff     = rd_over ? occupancy : rd_ext;

  assign wr_ready = IQ_WR_READY_FULL_GROUP ? (free_cnt >= CW'(WR_PORTS))
                                           : (free_cnt != '0);

  always_comb begin
    rd_valid = '0;
    for (int i = 0; i < RD_PORTS; i++) begin
      rd_valid[i] = occupancy > CW'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      ovf_err   <= 1'b0;
      udf_err   <= 1'b0;
    end else if (flush) begin
      // flush discards traffic but leaves sticky errors intact
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      wr_ptr    <= wr_ptr + PW'(w_eff);
      rd_ptr    <= rd_ptr + PW'(r_eff);
      occupancy <= occupancy + w_eff - r_eff;
      if (wr_over) ovf_err <= 1'b1;
      if (rd_over) udf_err <= 1'b1;
    end
  end

endmodule

// File: rtl/inst_queue_mp.sv
// Multi-port instruction queue between predecode and issue: count-based
// write/read lanes, storage array and zero-latency read mux.
module inst_queue_mp
  import inst_queue_mp_pkg::*;
#(
  parameter  int DEPTH    = IQ_DEPTH,
  parameter  int WR_PORTS = 2,
  parameter  int RD_PORTS = 2,
  localparam int CW       = $clog2(DEPTH + 1),
  localparam int PW       = $clog2(DEPTH),
  localparam int WCW      = $clog2(WR_PORTS + 1),
  localparam int RCW      = $clog2(RD_PORTS + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic [WCW-1:0]                   wr_cnt,
  input  pipe_entry_t [WR_PORTS-1:0]       wr_entry,
  output logic                             wr_ready,
  input  logic [RCW-1:0]                   rd_cnt,
  output pipe_entry_t [RD_PORTS-1:0]       rd_entry,
  output logic [RD_PORTS-1:0]              rd_valid,
  output logic [CW-1:0]                    occupancy,
  output logic [CW-1:0]                    free_cnt,
  output logic                             ovf_err,
  output logic                             udf_err
);

  pipe_entry_t   mem [DEPTH];
  logic          wr_accept;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  iq_ptr_ctrl #(
    .DEPTH    (DEPTH),
    .WR_PORTS (WR_PORTS),
    .RD_PORTS (RD_PORTS)
  ) u_ptr_ctrl (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .wr_cnt    (wr_cnt),
    .rd_cnt    (rd_cnt),
    .wr_accept (wr_accept),
    .wr_ptr    (wr_ptr),
    .rd_ptr    (rd_ptr),
    .occupancy (occupancy),
    .free_cnt  (free_cnt),
    .wr_ready  (wr_ready),
    .rd_valid  (rd_valid),
    .ovf_err   (ovf_err),
    .udf_err   (udf_err)
  );

  // Storage is intentionally not reset; rd_valid masks stale contents.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      for (int i = 0; i < WR_PORTS; i++) begin
        if (i < int'(wr_cnt)) mem[wr_ptr + PW'(i)] <= wr_entry[i];
      end
    end
  end

  always_comb begin
    rd_entry = '0;
    for (int i = 0; i < RD_PORTS; i++) begin
      if (rd_valid[i]) rd_entry[i] = mem[rd_ptr + PW'(i)];
    end
  end

endmodule

// File: tb/tb_inst_queue_mp.sv
// Directed bench for inst_queue_mp (DEPTH=16, 2 write / 2 read lanes).
module tb_inst_queue_mp;
  import inst_queue_mp_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               flush;
  logic [1:0]         wr_cnt;
  pipe_entry_t [1:0]  wr_entry;
  logic               wr_ready;
  logic [1:0]         rd_cnt;
  pipe_entry_t [1:0]  rd_entry;
  logic [1:0]         rd_valid;
  logic [4:0]         occupancy;
  logic [4:0]         free_cnt;
  logic               ovf_err;
  logic               udf_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inst_queue_mp #(.DEPTH(16), .WR_PORTS(2), .RD_PORTS(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .wr_cnt    (wr_cnt),
    .wr_entry  (wr_entry),
    .wr_ready  (wr_ready),
    .rd_cnt    (rd_cnt),
    .rd_entry  (rd_entry),
    .rd_valid  (rd_valid),
    .occupancy (occupancy),
    .free_cnt  (free_cnt),
    .ovf_err   (ovf_err),
    .udf_err   (udf_err)
  );

  typedef struct {
    logic       r;
    logic       f;
    logic [1:0] wc;
    logic [7:0] t0;
    logic [7:0] t1;
    logic [1:0] rc;
    logic [4:0] occ;
    logic [7:0] e0;
    logic [7:0] e1;
    logic       ovf;
    logic       udf;
  } vec_t;

  vec_t vecs [12];

  function automatic pipe_entry_t mk(input logic [7:0] t);
    pipe_entry_t p;
    p.pc   = {24'h000010, t};
    p.insn = {24'hA5C300, t};
    return p;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then check the state that results after the edge.
  task automatic step(input string name, input vec_t v);
    pipe_entry_t x0, x1;
    int          fr;
    rst         = v.r;
    flush       = v.f;
    wr_cnt      = v.wc;
    wr_entry[0] = mk(v.t0);
    wr_entry[1] = mk(v.t1);
    rd_cnt      = v.rc;
    @(posedge clk);
    #1;
    fr = 16 - int'(v.occ);
    x0 = (v.occ > 0) ? mk(v.e0) : '0;
    x1 = (v.occ > 1) ? mk(v.e1) : '0;
    chk({name, ".occupancy"}, 64'(occupancy), 64'(v.occ));
    chk({name, ".free_cnt"},  64'(free_cnt),  64'(fr));
    chk({name, ".wr_ready"},  64'(wr_ready),  64'(fr >= 2));
    chk({name, ".rd_valid"},  64'(rd_valid),  64'({v.occ > 1, v.occ > 0}));
    chk({name, ".rd_entry0"}, rd_entry[0],    x0);
    chk({name, ".rd_entry1"}, rd_entry[1],    x1);
    chk({name, ".ovf_err"},   64'(ovf_err),   64'(v.ovf));
    chk({name, ".udf_err"},   64'(udf_err),   64'(v.udf));
  endtask

  function automatic vec_t mv(input logic r, f, input logic [1:0] wc,
                              input logic [7:0] t0, t1, input logic [1:0] rc,
                              input logic [4:0] occ, input logic [7:0] e0, e1,
                              input logic ovf, udf);
    vec_t v;
    v.r = r; v.f = f; v.wc = wc; v.t0 = t0; v.t1 = t1; v.rc = rc;
    v.occ = occ; v.e0 = e0; v.e1 = e1; v.ovf = ovf; v.udf = udf;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //             r  f  wc  t0     t1     rc occ  e0     e1     ovf udf
    vecs[0]  = mv(1, 0, 0, 8'h00, 8'h00, 0, 0,  8'h00, 8'h00, 0, 0);
    vecs[1]  = mv(0, 0, 0, 8'h00, 8'h00, 0, 0,  8'h00, 8'h00, 0, 0);
    vecs[2]  = mv(0, 0, 2, 8'hA0, 8'hA1, 0, 2,  8'hA0, 8'hA1, 0, 0);
    vecs[3]  = mv(0, 0, 1, 8'hA2, 8'hEE, 0, 3,  8'hA0, 8'hA1, 0, 0);
    vecs[4]  = mv(0, 0, 0, 8'h00, 8'h00, 1, 2,  8'hA1, 8'hA2, 0, 0);
    vecs[5]  = mv(0, 0, 0, 8'h00, 8'h00, 2, 0,  8'h00, 8'h00, 0, 0);
    vecs[6]  = mv(0, 0, 2, 8'hD0, 8'hD1, 2, 2,  8'hD0, 8'hD1, 0, 1);
    vecs[7]  = mv(0, 0, 0, 8'h00, 8'h00, 1, 1,  8'hD1, 8'h00, 0, 1);
    vecs[8]  = mv(0, 0, 0, 8'h00, 8'h00, 2, 0,  8'h00, 8'h00, 0, 1);
    vecs[9]  = mv(0, 1, 2, 8'hE0, 8'hE1, 1, 0,  8'h00, 8'h00, 0, 1);
    vecs[10] = mv(0, 0, 1, 8'hF0, 8'hEE, 0, 1,  8'hF0, 8'h00, 0, 1);
    vecs[11] = mv(1, 0, 2, 8'hF1, 8'hF2, 2, 0,  8'h00, 8'h00, 0, 0);

    for (int k = 0; k < 12; k++) step($sformatf("tbl%0d", k), vecs[k]);

    // Fill to DEPTH, then a same-cycle read does not make room for a write.
    for (int k = 0; k < 8; k++)
      step($sformatf("fill%0d", k),
           mv(0, 0, 2, 8'(8'h10 + 2*k), 8'(8'h11 + 2*k), 0, 5'(2*k + 2), 8'h10, 8'h11, 0, 0));
    step("full_rw", mv(0, 0, 2, 8'h30, 8'h31, 2, 14, 8'h12, 8'h13, 1, 0));
    step("full_rw_next", mv(0, 0, 0, 8'h00, 8'h00, 2, 12, 8'h14, 8'h15, 1, 0));
    step("rst_a", mv(1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0));

    // Walk both pointers to 15, then write a pair straddling the wrap.
    step("prime0", mv(0, 0, 1, 8'h40, 8'hEE, 0, 1, 8'h40, 8'h00, 0, 0));
    for (int k = 1; k < 15; k++)
      step($sformatf("prime%0d", k),
           mv(0, 0, 1, 8'(8'h40 + k), 8'hEE, 1, 1, 8'(8'h40 + k), 8'h00, 0, 0));
    step("prime_drain", mv(0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 0, 0));
    step("wrap_wr", mv(0, 0, 2, 8'h58, 8'h59, 0, 2, 8'h58, 8'h59, 0, 0));
    step("wrap_rd1", mv(0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h59, 8'h00, 0, 0));
    step("udf_occ1", mv(0, 0, 0, 8'h00, 8'h00, 2, 0, 8'h00, 8'h00, 0, 1));

    // Flush with five entries held plus a concurrent write.
    step("pre_fl0", mv(0, 0, 2, 8'h60, 8'h61, 0, 2, 8'h60, 8'h61, 0, 1));
    step("pre_fl1", mv(0, 0, 2, 8'h62, 8'h63, 0, 4, 8'h60, 8'h61, 0, 1));
    step("pre_fl2", mv(0, 0, 1, 8'h64, 8'hEE, 0, 5, 8'h60, 8'h61, 0, 1));
    step("flush5", mv(0, 1, 2, 8'h65, 8'h66, 2, 0, 8'h00, 8'h00, 0, 1));

    // Reset mid-stream with occupancy 9 and a write pending.
    for (int k = 0; k < 4; k++)
      step($sformatf("pre_rst%0d", k),
           mv(0, 0, 2, 8'(8'h70 + 2*k), 8'(8'h71 + 2*k), 0, 5'(2*k + 2), 8'h70, 8'h71, 0, 1));
    step("pre_rst4", mv(0, 0, 1, 8'h78, 8'hEE, 0, 9, 8'h70, 8'h71, 0, 1));
    step("rst_mid", mv(1, 0, 2, 8'h79, 8'h7A, 1, 0, 8'h00, 8'h00, 0, 0));
    step("post_rst", mv(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
